// File: rtl/aes_inv_cipher_core.sv
// rtl/aes_inv_cipher_core.sv - AES-128 iterative inverse cipher with on-chip round-key expansion

// Multiplicative inverse in GF(2^8) modulo x^8+x^4+x^3+x+1, computed as a^254 (inverse of 0 is 0)
module aes_gf_inv (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] acc;

  // Square-and-multiply: accumulate a^2 * a^4 * ... * a^128 = a^254
  always_comb begin
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    y = acc;
  end
endmodule

// Forward S-box: field inverse followed by the affine transform
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] b;

  aes_gf_inv u_inv (.a(a), .y(b));

  assign y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform followed by the field inverse
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] t;

  assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;

  aes_gf_inv u_inv (.a(t), .y(y));
endmodule

module aes_inv_cipher_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  output logic         key_ready,
  input  logic         ld,
  input  logic [127:0] text_in,
  output logic [127:0] text_out,
  output logic         done,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t       state, state_nxt;
  logic [127:0] rk [0:10];
  logic [127:0] wkey;
  logic [3:0]   kcnt;
  logic         expanding;
  logic [3:0]   rnd;
  logic [127:0] st;
  logic         start;

  // ---------------- key expansion ----------------
  logic [31:0]  rot_w, sub_w, temp;
  logic [7:0]   rcon;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] key_nxt;

  assign rot_w = {wkey[23:0], wkey[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_ksbox
    aes_sbox u_sbox (.a(rot_w[8*g +: 8]), .y(sub_w[8*g +: 8]));
  end

  // Round constant for the round key currently being produced
  always_comb begin
    rcon = 8'h00;
    case (kcnt)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign temp    = sub_w ^ {rcon, 24'h000000};
  assign n0      = wkey[127:96] ^ temp;
  assign n1      = wkey[95:64] ^ n0;
  assign n2      = wkey[63:32] ^ n1;
  assign n3      = wkey[31:0] ^ n2;
  assign key_nxt = {n0, n1, n2, n3};

  // Round-key file: no reset, key_ready gates its use
  always_ff @(posedge clk) begin
    if (kld) rk[0] <= key;
    else if (expanding) rk[kcnt] <= key_nxt;
  end

  // ---------------- round datapath ----------------
  logic [127:0] sr_v, sb_v, ark, imc;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int D = 4*c + r;
      localparam int S = 4*((c - r + 4) % 4) + r;
      assign sr_v[127-8*D -: 8] = st[127-8*S -: 8];
      aes_inv_sbox u_isbox (.a(sr_v[127-8*D -: 8]), .y(sb_v[127-8*D -: 8]));
    end
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  // rnd reaches 0 on entry to FINAL, so rk[rnd] also supplies rk[0] for the last round
  assign ark   = sb_v ^ rk[rnd];
  assign imc   = inv_mix(ark);
  assign start = (state == IDLE) && ld && key_ready && !kld;
  assign busy  = (state != IDLE);

  // ---------------- control ----------------
  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; a key load aborts any decryption
  always_comb begin
    state_nxt = state;
    if (kld) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = ROUND;
        ROUND:   if (rnd == 4'd1) state_nxt = FINAL;
        FINAL:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Expansion sequencing, round state, round counter and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wkey      <= '0;
      kcnt      <= '0;
      expanding <= 1'b0;
      key_ready <= 1'b0;
      rnd       <= '0;
      st        <= '0;
      text_out  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kld) begin
        wkey      <= key;
        kcnt      <= 4'd1;
        expanding <= 1'b1;
        key_ready <= 1'b0;
      end else if (expanding) begin
        wkey <= key_nxt;
        kcnt <= kcnt + 4'd1;
        if (kcnt == 4'd10) begin
          expanding <= 1'b0;
          key_ready <= 1'b1;
        end
      end
      if (start) begin
        st  <= text_in ^ rk[10];
        rnd <= 4'd9;
      end else if (!kld && state == ROUND) begin
        st  <= imc;
        rnd <= rnd - 4'd1;
      end else if (!kld && state == FINAL) begin
        text_out <= ark;
        done     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// tb/tb_aes_inv_cipher_core.sv - self-checking bench for aes_inv_cipher_core
module tb_aes_inv_cipher_core;
  logic         clk;
  logic         rst;
  logic         kld;
  logic [127:0] key;
  logic         key_ready;
  logic         ld;
  logic [127:0] text_in;
  logic [127:0] text_out;
  logic         done;
  logic         busy;

  int checks;
  int errors;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  aes_inv_cipher_core dut (
    .clk(clk), .rst(rst), .kld(kld), .key(key), .key_ready(key_ready),
    .ld(ld), .text_in(text_in), .text_out(text_out), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  // ---------------- reference model: forward AES-128 ----------------
  logic [7:0] sbox_t [0:255];

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
    return (x << s) | (x >> (8 - s));
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 0; aa = a; bb = b;
    while (bb != 0) begin
      if (bb[0]) p ^= aa;
      aa = (aa[7]) ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ ((p & 8'h80) != 0 ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] ^= w[c][31-8*r -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (rd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] ^= w[4*rd+c][31-8*r -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k, input string name);
    kld = 1'b1; key = k;
    tick();
    kld = 1'b0;
    checks++;
    if (key_ready !== 1'b0) begin
      errors++; $display("FAIL %s key_ready_drop: got %0b want 0", name, key_ready);
    end
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (key_ready !== (e == 10)) begin
        errors++; $display("FAIL %s key_ready_edge%0d: got %0b want %0b", name, e, key_ready, (e == 10));
      end
    end
  endtask

  task automatic run_decrypt(input logic [127:0] ct, input logic [127:0] exp,
                             input string name, input int extra_ld_at);
    ld = 1'b1; text_in = ct;
    tick();
    ld = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_rise: got %0b want 1", name, busy);
    end
    for (int e = 1; e <= 10; e++) begin
      if (e == extra_ld_at) begin ld = 1'b1; text_in = ~ct; end
      tick();
      ld = 1'b0;
      if (e < 10) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL %s run_edge%0d: done=%0b busy=%0b want done=0 busy=1", name, e, done, busy);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s finish: done=%0b busy=%0b want done=1 busy=0", name, done, busy);
    end
    checks++;
    if (text_out !== exp) begin
      errors++; $display("FAIL %s text_out: got %h want %h", name, text_out, exp);
    end
    text_in = '0;
    tick();
    checks++;
    if (done !== 1'b0 || text_out !== exp) begin
      errors++; $display("FAIL %s hold: done=%0b text_out=%h want done=0 text_out=%h", name, done, text_out, exp);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; kld = 1'b0; ld = 1'b0; key = '0; text_in = '0;
    tick(); tick();
    checks++;
    if (key_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || text_out !== '0) begin
      errors++; $display("FAIL reset: key_ready=%0b busy=%0b done=%0b text_out=%h want all 0",
                         key_ready, busy, done, text_out);
    end
    rst = 1'b1;
    ld = 1'b1; text_in = C1_CT;
    tick();
    ld = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_ld_ignored: busy=%0b want 0", busy);
    end
  endtask

  task automatic test_fips() ;
    load_key(C1_KEY, "c1");
    run_decrypt(C1_CT, C1_PT, "c1", 0);
    load_key(B_KEY, "b");
    run_decrypt(B_CT, B_PT, "b", 0);
  endtask

  task automatic test_ignored_ld();
    kld = 1'b1; key = C1_KEY;
    tick();
    kld = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      if (e == 3) begin ld = 1'b1; text_in = B_CT; end
      tick();
      ld = 1'b0;
      if (e == 3) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL ign_ld_before_ready: busy=%0b want 0", busy);
        end
      end
    end
    checks++;
    if (key_ready !== 1'b1) begin
      errors++; $display("FAIL ign_key_ready: got %0b want 1", key_ready);
    end
    run_decrypt(C1_CT, C1_PT, "ign_busy", 4);
    for (int e = 0; e < 12; e++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL ign_extra_done: cycle %0d done=%0b busy=%0b want 0 0", e, done, busy);
      end
    end
  endtask

  task automatic test_kld_same_cycle();
    logic [127:0] prev;
    prev = text_out;
    ld = 1'b1; text_in = C1_CT; kld = 1'b1; key = B_KEY;
    tick();
    ld = 1'b0; kld = 1'b0;
    checks++;
    if (busy !== 1'b0 || key_ready !== 1'b0) begin
      errors++; $display("FAIL kld_wins: busy=%0b key_ready=%0b want 0 0", busy, key_ready);
    end
    for (int e = 1; e <= 10; e++) tick();
    checks++;
    if (key_ready !== 1'b1 || text_out !== prev) begin
      errors++; $display("FAIL kld_wins_after: key_ready=%0b text_out=%h want 1 %h", key_ready, text_out, prev);
    end
    run_decrypt(B_CT, B_PT, "kld_wins_dec", 0);
  endtask

  task automatic test_kld_abort();
    logic [127:0] prev;
    load_key(C1_KEY, "abort_key");
    prev = text_out;
    ld = 1'b1; text_in = C1_CT;
    tick();
    ld = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    kld = 1'b1; key = B_KEY;
    tick();
    kld = 1'b0;
    checks++;
    if (busy !== 1'b0 || key_ready !== 1'b0 || done !== 1'b0 || text_out !== prev) begin
      errors++; $display("FAIL kld_abort: busy=%0b key_ready=%0b done=%0b text_out=%h want 0 0 0 %h",
                         busy, key_ready, done, text_out, prev);
    end
    for (int e = 6; e <= 15; e++) begin
      tick();
      checks++;
      if (done !== 1'b0 || key_ready !== (e == 15) || text_out !== prev) begin
        errors++; $display("FAIL kld_abort_edge%0d: done=%0b key_ready=%0b want 0 %0b", e, done, key_ready, (e == 15));
      end
    end
    run_decrypt(B_CT, B_PT, "kld_abort_dec", 0);
  endtask

  task automatic test_reset_abort();
    load_key(B_KEY, "rst_key");
    ld = 1'b1; text_in = B_CT;
    tick();
    ld = 1'b0;
    for (int e = 1; e <= 3; e++) tick();
    #5;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || key_ready !== 1'b0 || text_out !== '0) begin
      errors++; $display("FAIL rst_abort: busy=%0b done=%0b key_ready=%0b text_out=%h want all 0",
                         busy, done, key_ready, text_out);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rst_no_done: cycle %0d done=%0b busy=%0b want 0 0", e, done, busy);
      end
    end
    ld = 1'b1; text_in = B_CT;
    tick();
    ld = 1'b0;
    checks++;
    if (busy !== 1'b0 || key_ready !== 1'b0) begin
      errors++; $display("FAIL rst_ld_ignored: busy=%0b key_ready=%0b want 0 0", busy, key_ready);
    end
    load_key(B_KEY, "rst_reload");
    run_decrypt(B_CT, B_PT, "rst_dec", 0);
  endtask

  task automatic test_back_to_back();
    load_key(C1_KEY, "b2b_key");
    ld = 1'b1; text_in = C1_CT;
    tick();
    ld = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      tick();
      ld = 1'b0;
      checks++;
      if (done !== (e == 10 || e == 21)) begin
        errors++; $display("FAIL b2b_done_edge%0d: got %0b want %0b", e, done, (e == 10 || e == 21));
      end
      if (e == 10 || e == 21) begin
        checks++;
        if (text_out !== C1_PT) begin
          errors++; $display("FAIL b2b_text_edge%0d: got %h want %h", e, text_out, C1_PT);
        end
      end
      if (e == 11) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL b2b_second_accept: busy=%0b want 1", busy);
        end
      end
      if (e == 10) begin ld = 1'b1; text_in = C1_CT; end
    end
    tick();
  endtask

  task automatic test_random();
    logic [127:0] k, pt, ct;
    for (int n = 0; n < 4; n++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = model_encrypt(k, pt);
      load_key(k, "rand_key");
      run_decrypt(ct, pt, "rand_dec", 0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    build_sbox();
    test_reset();
    test_fips();
    test_ignored_ld();
    test_kld_same_cycle();
    test_kld_abort();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
